fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and F/D pipeline register of the 5-stage RV32I core.
- Owns the PC, drives the synchronous instruction memory (1-cycle read latency) and presents fPc, fInst, fRs1 and fRs2 to decode and to the load-use hazard unit.
- Consumes pcStall/fStall from the load-use hazard unit and the branch/jump redirect from EX.
- Keeps the fetched word stable across stalls with a hold buffer, because imem is not re-read while stalled.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word presented for bubbles (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- pcStall  in  1  hold PC (from hazard unit)
- fStall  in  1  hold F/D register (from hazard unit); always equal to pcStall
- brTaken  in  1  EX-stage redirect; also flushes F/D
- brTarget  in  32  redirect address, word aligned
- imemEn  out  1  imem read enable
- imemAddr  out  32  imem read address
- imemRdata  in  32  imem data, valid the cycle after imemEn=1
- fValid  out  1  F/D holds a real instruction
- fPc  out  32  PC of the F/D instruction
- fInst  out  32  F/D instruction word
- fRs1  out  5  fInst[19:15], forced to 0 when fValid=0
- fRs2  out  5  fInst[24:20], forced to 0 when fValid=0

Behaviour:
- Reset (async, rstn=0): pc=PC_RESET, fValid=0, fPc=0, hold=NOP_INST, state=RUN.
  - Outputs during reset: fInst=NOP_INST, fRs1=fRs2=0, imemEn=1, imemAddr=PC_RESET.
- Combinational outputs:
  - imemAddr = pc.
  - imemEn = ~fStall | brTaken.
  - fInst = !fValid ? NOP_INST : (state==HOLD ? hold : imemRdata).
- Read alignment: the read issued with address pc in cycle t returns in t+1, the same cycle fPc=pc(t) is visible.
- State RUN:
  - Advance edge (no stall, no redirect): fPc<=pc, fValid<=1, pc<=pc+4 (32-bit wrap, no trap).
  - Stall edge (fStall=1, no redirect): hold<=imemRdata, state<=HOLD; pc, fPc and fValid unchanged.
- State HOLD:
  - fInst comes from hold.
  - Stall edge: hold unchanged.
  - Advance edge: state<=RUN, fPc<=pc, pc<=pc+4.
    - The read issued during the release cycle supplies the next fInst.
- Redirect edge (brTaken=1): pc<=brTarget, fValid<=0, state<=RUN, regardless of stalls.
  - The instruction in F/D is squashed.
  - The read issued at the old pc is ignored because fValid=0.
  - The next cycle issues a read at brTarget; the edge after that, fPc<=brTarget and fValid<=1.
- Priority: redirect > stall > advance.
- Bubbles: fValid=0 forces fRs1=fRs2=0, so the hazard unit never stalls on a bubble.
- Mid-operation reset: async clear to the reset values above. The hold contents are discarded.
- Latency: first valid fInst (PC_RESET) appears in the second cycle after rstn deasserts.
- Illegal input: pcStall != fStall is not supported and is flagged by an assertion.
- Instruction memory is read-only from this block. Misaligned brTarget is not checked.

Decomposition:
- Shared package core_pkg:
  - XLEN=32.
  - NOP_INST.
  - Fetch state encoding RUN/HOLD.
  - Register-field slice constants RS1_MSB/LSB, RS2_MSB/LSB.
- One sub-module: fetch_hold_buf. It contains the hold register, the state flop and the fInst mux.
- PC update and the F/D register stay in fetch_stage.

Test Plan:
- Reset then run, imem word at addr = {addr[15:0],16'h0013}:
  - fValid rises 2 cycles after rstn.
  - fPc steps 0, 4, 8, 12.
  - fInst tracks the memory words.
- Load-use stall: fStall=pcStall=1 for 2 cycles while fPc=8:
  - imemEn=0 for those 2 cycles.
  - fPc=8 and fInst=mem[8] are held stable.
  - Then fPc=12, fInst=mem[12], with no skipped or repeated instruction.
- Redirect with no stall: brTaken=1, brTarget=0x40 while fPc=0x10:
  - The next cycle shows fValid=0, fInst=0x13, fRs1=fRs2=0.
  - The following cycle shows fPc=0x40, fValid=1.
- Redirect during stall (brTaken=1 while fStall=1 in HOLD):
  - Redirect wins and state returns to RUN.
  - fPc=brTarget appears 2 cycles later.
- Async reset mid-stall: pull rstn low between edges while in HOLD:
  - fValid=0 and imemAddr=PC_RESET immediately.
  - The restart sequence matches the first scenario.
- Wrap: PC_RESET=32'hFFFF_FFF8, run 3 cycles -> fPc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: data width, bubble instruction, fetch FSM states
// and the register-field positions inside an RV32I instruction word.
package core_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 is what decode sees whenever F/D holds no real instruction
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetchStateT;

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage, the synchronous instruction memory and decode.
interface fetch_stage_if;
    import core_pkg::*;

    logic            imemEn;
    logic [XLEN-1:0] imemAddr;
    logic [XLEN-1:0] imemRdata;
    logic            fValid;
    logic [XLEN-1:0] fPc;
    logic [XLEN-1:0] fInst;
    logic [4:0]      fRs1;
    logic [4:0]      fRs2;

    modport master (
        output imemEn, imemAddr, fValid, fPc, fInst, fRs1, fRs2,
        input  imemRdata
    );

    modport slave (
        input  imemEn, imemAddr, fValid, fPc, fInst, fRs1, fRs2,
        output imemRdata
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// Hold buffer for the fetched word: imem is not re-read while the pipeline is
// stalled, so the word that was on imemRdata at the stall edge is captured and
// presented to decode until the stall releases.
module fetch_hold_buf
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            redirect,
    input  logic            fValid,
    input  logic [XLEN-1:0] imemRdata,
    output logic [XLEN-1:0] fInst
);

    fetchStateT      state;
    fetchStateT      stateNext;
    logic [XLEN-1:0] hold;
    logic [XLEN-1:0] holdNext;

    // State and hold registers; reset discards any captured word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
            hold  <= NOP_INST;
        end else begin
            state <= stateNext;
            hold  <= holdNext;
        end
    end

    // Next state (redirect beats stall) and the word presented to decode
    always_comb begin
        stateNext = state;
        holdNext  = hold;
        if (redirect) begin
            stateNext = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        holdNext  = imemRdata;
                        stateNext = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        stateNext = RUN;
                    end
                end
                default: stateNext = RUN;
            endcase
        end
        if (!fValid) begin
            fInst = NOP_INST;
        end else if (state == HOLD) begin
            fInst = hold;
        end else begin
            fInst = imemRdata;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and F/D pipeline register. Owns the PC, drives the
// 1-cycle-latency instruction memory and presents the fetched instruction and
// its source-register fields to decode and the load-use hazard unit.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            pcStall,
    input  logic            fStall,
    input  logic            brTaken,
    input  logic [XLEN-1:0] brTarget,
    fetch_stage_if.master   bus
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fPcQ;
    logic            fValidQ;
    logic [XLEN-1:0] instWord;

    // PC and F/D register: redirect squashes F/D, stall freezes, else advance
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc      <= PC_RESET;
            fPcQ    <= '0;
            fValidQ <= 1'b0;
        end else if (brTaken) begin
            pc      <= brTarget;
            fValidQ <= 1'b0;
        end else begin
            if (!pcStall) begin
                pc <= pc + 32'd4;
            end
            if (!fStall) begin
                fPcQ    <= pc;
                fValidQ <= 1'b1;
            end
        end
    end

    fetch_hold_buf #(
        .NOP_INST (NOP_INST)
    ) holdBuf (
        .clk       (clk),
        .rstn      (rstn),
        .stall     (fStall),
        .redirect  (brTaken),
        .fValid    (fValidQ),
        .imemRdata (bus.imemRdata),
        .fInst     (instWord)
    );

    // A redirect must fetch even under a stall, because the stall belongs to
    // the instruction being squashed
    assign bus.imemEn   = ~fStall | brTaken;
    assign bus.imemAddr = pc;
    assign bus.fValid   = fValidQ;
    assign bus.fPc      = fPcQ;
    assign bus.fInst    = instWord;
    // Bubbles report x0 sources so the hazard unit never stalls on them
    assign bus.fRs1     = fValidQ ? instWord[RS1_MSB:RS1_LSB] : 5'd0;
    assign bus.fRs2     = fValidQ ? instWord[RS2_MSB:RS2_LSB] : 5'd0;

    // The hazard unit always drives both stall lines together
    stallsAgree: assert property (@(posedge clk) disable iff (!rstn) pcStall == fStall);

endmodule
